// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: instruction fetch FSM feeding a circular {pc, instruction} FIFO with flush/redirect
module inst_prefetch_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] redirect_addr,
   input  logic                  pc_en,
   output logic                  mem_req,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] instruction_if,
   output logic [DATA_WIDTH-1:0] pc_if,
   output logic                  inst_valid
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h13);
   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
   state_t state, state_next;
   logic [DATA_WIDTH-1:0] fetch_pc, fetch_pc_next, addr_next, seq_addr;
   logic [DATA_WIDTH-1:0] pc_q [DEPTH];
   logic [DATA_WIDTH-1:0] inst_q [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count, count_next;
   logic push, pop;
   assign pop = pc_en && inst_valid && !flush;
   assign push = state == WAIT && mem_ack && !flush;
   assign count_next = flush ? '0 : count + CW'(push) - CW'(pop);
   assign seq_addr = mem_addr + DATA_WIDTH'(4);
   assign mem_req = state != IDLE;
   assign inst_valid = count != '0;
   assign instruction_if = inst_valid ? inst_q[rptr] : NOP;
   assign pc_if = inst_valid ? pc_q[rptr] : '0;
   always_comb begin
      state_next = state;
      fetch_pc_next = flush ? redirect_addr : fetch_pc;
      addr_next = mem_addr;
      case (state)
         IDLE: if (!flush && count_next < CW'(DEPTH)) begin
            state_next = WAIT;
            addr_next = fetch_pc;
         end
         WAIT: if (flush) state_next = mem_ack ? IDLE : DISCARD;
         else if (mem_ack) begin
            fetch_pc_next = seq_addr;
            if (count_next < CW'(DEPTH)) addr_next = seq_addr;
            else state_next = IDLE;
         end
         DISCARD: if (mem_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         count <= '0;
         wptr <= '0;
         rptr <= '0;
         fetch_pc <= RESET_PC;
         mem_addr <= RESET_PC;
      end else begin
         state <= state_next;
         count <= count_next;
         fetch_pc <= fetch_pc_next;
         mem_addr <= addr_next;
         wptr <= flush ? '0 : push ? wptr + PW'(1) : wptr;
         rptr <= flush ? '0 : pop ? rptr + PW'(1) : rptr;
      end
   always_ff @(posedge clk)
      if (push) begin
         pc_q[wptr] <= mem_addr;
         inst_q[wptr] <= mem_rdata;
      end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed checks of fetch, backpressure, flush, wrap and async reset
module tb_inst_prefetch_queue;
   logic clk = 0, reset = 0, flush = 0, pc_en = 0, zw = 1, ack_drv = 0;
   logic [31:0] redirect_addr = '0;
   logic mem_req, mem_ack, inst_valid;
   logic [31:0] mem_addr, mem_rdata, instruction_if, pc_if;
   logic b_req, b_valid;
   logic [31:0] b_addr, b_rdata, b_inst, b_pc;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   assign mem_ack = zw ? mem_req : ack_drv;
   assign mem_rdata = mem_addr + 32'h1000_0000;
   assign b_rdata = b_addr + 32'h1000_0000;
   inst_prefetch_queue dut (
      .clk(clk), .reset(reset), .flush(flush), .redirect_addr(redirect_addr), .pc_en(pc_en),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instruction_if(instruction_if), .pc_if(pc_if), .inst_valid(inst_valid)
   );
   inst_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .reset(reset), .flush(1'b0), .redirect_addr(32'h0), .pc_en(1'b1),
      .mem_req(b_req), .mem_addr(b_addr), .mem_ack(b_req), .mem_rdata(b_rdata),
      .instruction_if(b_inst), .pc_if(b_pc), .inst_valid(b_valid)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      pc_en = 1;
      tick();
      tick();
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_valid", 32'(inst_valid), 0);
      chk("rst_inst", instruction_if, 32'h13);
      chk("rst_pc", pc_if, 0);
      chk("rst_wrap_addr", b_addr, 32'hFFFF_FFF8);
      reset = 1;
      tick();
      chk("zw_req1", 32'(mem_req), 1);
      chk("zw_valid1", 32'(inst_valid), 0);
      tick();
      chk("zw_valid2", 32'(inst_valid), 1);
      chk("zw_pc0", pc_if, 0);
      chk("zw_inst0", instruction_if, 32'h1000_0000);
      chk("wrap_pc0", b_pc, 32'hFFFF_FFF8);
      tick();
      chk("zw_pc4", pc_if, 4);
      chk("wrap_pc1", b_pc, 32'hFFFF_FFFC);
      tick();
      chk("zw_pc8", pc_if, 8);
      chk("wrap_pc2", b_pc, 0);
      chk("wrap_inst2", b_inst, 32'h1000_0000);
      tick();
      chk("zw_pc12", pc_if, 12);
      reset = 0;
      pc_en = 0;
      tick();
      reset = 1;
      repeat (4) tick();
      chk("bp_req_c3", 32'(mem_req), 1);
      chk("bp_addr_c3", mem_addr, 12);
      tick();
      chk("bp_full_req", 32'(mem_req), 0);
      chk("bp_full_pc", pc_if, 0);
      tick();
      chk("bp_idle_req", 32'(mem_req), 0);
      pc_en = 1;
      tick();
      pc_en = 0;
      chk("bp_refetch_req", 32'(mem_req), 1);
      chk("bp_refetch_addr", mem_addr, 16);
      chk("bp_pop_pc", pc_if, 4);
      tick();
      chk("bp_one_req", 32'(mem_req), 0);
      tick();
      chk("bp_one_req2", 32'(mem_req), 0);
      reset = 0;
      zw = 0;
      ack_drv = 0;
      tick();
      reset = 1;
      tick();
      chk("lat_addr0", mem_addr, 0);
      flush = 1;
      redirect_addr = 32'h100;
      tick();
      flush = 0;
      chk("disc_req", 32'(mem_req), 1);
      chk("disc_addr_held", mem_addr, 0);
      tick();
      ack_drv = 1;
      tick();
      ack_drv = 0;
      chk("disc_drop_valid", 32'(inst_valid), 0);
      chk("disc_idle_req", 32'(mem_req), 0);
      tick();
      chk("redir_req", 32'(mem_req), 1);
      chk("redir_addr", mem_addr, 32'h100);
      ack_drv = 1;
      tick();
      chk("redir_pc", pc_if, 32'h100);
      chk("redir_inst", instruction_if, 32'h1000_0100);
      tick();
      chk("cnt2_addr", mem_addr, 32'h108);
      flush = 1;
      redirect_addr = 32'h200;
      pc_en = 1;
      tick();
      flush = 0;
      pc_en = 0;
      ack_drv = 0;
      chk("fack_valid", 32'(inst_valid), 0);
      chk("fack_req", 32'(mem_req), 0);
      chk("fack_inst", instruction_if, 32'h13);
      chk("fack_pc", pc_if, 0);
      tick();
      chk("fack_redir_req", 32'(mem_req), 1);
      chk("fack_redir_addr", mem_addr, 32'h200);
      #2;
      reset = 0;
      #1;
      chk("areset_req", 32'(mem_req), 0);
      chk("areset_addr", mem_addr, 0);
      chk("areset_valid", 32'(inst_valid), 0);
      zw = 1;
      tick();
      reset = 1;
      tick();
      chk("areset_refetch_req", 32'(mem_req), 1);
      chk("areset_refetch_addr", mem_addr, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 The block SHALL use parameter DATA_WIDTH, default 32, as the instruction and address width.
REQ-002 The block SHALL use parameter DEPTH, default 4, as the number of queue entries (power of two, >= 2).
REQ-003 The block SHALL use parameter RESET_PC, default 32'h0000_0000, as the first fetch address.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and reset.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port flush, input, 1 bit: discard the queue and redirect fetch.
REQ-008 The block SHALL have port redirect_addr, input, DATA_WIDTH: new fetch address, sampled when flush=1.
REQ-009 The block SHALL have port pc_en, input, 1 bit: consumer pops the head entry when pc_en=1 and inst_valid=1.
REQ-010 The block SHALL have port mem_req, output, 1 bit: instruction memory read request.
REQ-011 The block SHALL have port mem_addr, output, DATA_WIDTH: word address of the request.
REQ-012 The block SHALL have port mem_ack, input, 1 bit: mem_rdata is valid this cycle and the request is complete.
REQ-013 The block SHALL have port mem_rdata, input, DATA_WIDTH: fetched instruction word.
REQ-014 The block SHALL have port instruction_if, output, DATA_WIDTH: head instruction.
REQ-015 The block SHALL have port pc_if, output, DATA_WIDTH: address of the head instruction.
REQ-016 The block SHALL have port inst_valid, output, 1 bit: the head entry is valid.

Function
REQ-017 The queue SHALL be a DEPTH-entry circular FIFO of {pc, instruction} pairs, with read/write pointers wrapping modulo DEPTH and an occupancy count from 0 to DEPTH.
REQ-018 The head outputs SHALL drive from registered storage: inst_valid=(count!=0), instruction_if/pc_if=head entry when valid, else 32'h0000_0013 (NOP) and 0.
REQ-019 The FSM SHALL have exactly three states: IDLE (no request outstanding), WAIT (request outstanding), DISCARD (outstanding request whose data is to be dropped).
REQ-020 mem_req SHALL equal 1 exactly in WAIT and DISCARD; mem_addr SHALL hold stable from request start until the cycle of mem_ack.
REQ-021 IDLE SHALL transition to WAIT with mem_addr=fetch_pc when flush=0 and the next-cycle count < DEPTH.
REQ-022 In WAIT with mem_ack=1 and flush=0, the block SHALL push {mem_addr, mem_rdata}, set fetch_pc to mem_addr+4, and stay in WAIT with the new address if the next count < DEPTH, else go to IDLE.
REQ-023 Back-to-back acks SHALL sustain one instruction per cycle.
REQ-024 A simultaneous push and pop SHALL leave count unchanged.
REQ-025 A pop SHALL never occur when empty, and a push SHALL never occur when full; the request gating guarantees the latter.
REQ-026 Address arithmetic SHALL be modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 On flush=1, the queue SHALL be emptied at the clock edge (count=0, pointers=0), any pop that cycle SHALL be ignored, and fetch_pc SHALL be set to redirect_addr.
REQ-028 On flush in WAIT with mem_ack=0, the FSM SHALL go to DISCARD and the old mem_addr SHALL stay held.
REQ-029 On flush in WAIT with mem_ack=1, the data SHALL be dropped and the FSM SHALL go to IDLE.
REQ-030 On flush in IDLE, the FSM SHALL stay IDLE for that cycle.
REQ-031 DISCARD SHALL drop data on mem_ack and then go to IDLE.
REQ-032 A further flush in DISCARD SHALL only update fetch_pc.
REQ-033 The first fetch from redirect_addr SHALL be requested no later than 1 cycle after leaving DISCARD/IDLE.
REQ-034 With a zero-wait memory (mem_ack=1 whenever mem_req=1), the first instruction SHALL show inst_valid=1 two cycles after reset deassertion.

Reset
REQ-035 While reset=0, the block SHALL asynchronously set: state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, inst_valid=0, instruction_if=32'h0000_0013, pc_if=0.
REQ-036 Reset asserted mid-request SHALL abandon the request without waiting for mem_ack, and any later mem_ack SHALL be ignored while in IDLE.

Verification
REQ-037 Zero-wait memory, pc_en=1 constantly -> pc_if sequence 0,4,8,12 on consecutive cycles, inst_valid=1 from the 2nd cycle after reset release.
REQ-038 pc_en=0, zero-wait memory -> count reaches 4, mem_req falls to 0, pc_if stays 0; raising pc_en for one cycle -> exactly one new fetch, at address 16.
REQ-039 3-cycle ack latency, flush with redirect_addr=32'h100 on the 1st wait cycle -> the ack'd word is not queued, and the next mem_addr=32'h100.
REQ-040 flush coincident with mem_ack and pc_en=1 at count=2 -> count=0, inst_valid=0 next cycle, and the next request is at redirect_addr.
REQ-041 RESET_PC=32'hFFFF_FFF8, zero-wait memory -> fetched pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-042 reset pulsed low while in WAIT -> mem_req=0 immediately (asynchronously), and after release the first mem_addr=RESET_PC.
